// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dual-requester data-SRAM arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
endpackage

// File: rtl/dmem_arb_picker.sv
// Winner selection for dmem_arbiter. DMEM_ARB_RR_EN selects round-robin on ties;
// otherwise CPU has fixed priority with aux aging after STARVE_LIMIT losses.
module dmem_arb_picker
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_grant,
  input  logic i_cpu_req,
  input  logic i_aux_req,
  output logic o_winner
);
`ifdef DMEM_ARB_RR_EN
  logic r_last_winner;

  always_comb begin
    o_winner = REQ_CPU;
    if (i_cpu_req && i_aux_req) o_winner = ~r_last_winner;
    else if (i_aux_req)         o_winner = REQ_AUX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_last_winner <= REQ_AUX;
    else if (i_grant) r_last_winner <= o_winner;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  always_comb begin
    o_winner = REQ_CPU;
    if (i_cpu_req && i_aux_req) o_winner = (r_starve_cnt == LIMIT) ? REQ_AUX : REQ_CPU;
    else if (i_aux_req)         o_winner = REQ_AUX;
  end

  // Only a tie lost by aux ages it; any aux win resets the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_starve_cnt <= '0;
    else if (i_grant) begin
      if (o_winner == REQ_AUX)                   r_starve_cnt <= '0;
      else if (i_aux_req && r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between the CPU and aux ports; IDLE->ACCESS->DONE.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking instead of fixed CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_aux_req,
  input  logic              i_aux_we,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_wdata,
  output logic              o_aux_ack,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic              o_sram_oen,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic [DATA_W-1:0] o_sram_d,
  input  logic [DATA_W-1:0] i_sram_q
);
  state_t r_state;
  logic   r_win, r_we;
  logic   w_grant, w_winner, w_we;

  assign w_grant = (r_state == IDLE) && (i_cpu_req || i_aux_req);
  assign w_we    = (w_winner == REQ_AUX) ? i_aux_we : i_cpu_we;

  dmem_arb_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_grant   (w_grant),
    .i_cpu_req (i_cpu_req),
    .i_aux_req (i_aux_req),
    .o_winner  (w_winner)
  );

  // SRAM pins are registered one cycle ahead so they are stable for the ACCESS negedge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_win       <= REQ_CPU;
      r_we        <= 1'b0;
      o_cpu_ack   <= 1'b0;
      o_aux_ack   <= 1'b0;
      o_cpu_rdata <= '0;
      o_aux_rdata <= '0;
      o_sram_cen  <= 1'b1;
      o_sram_wen  <= 1'b1;
      o_sram_oen  <= 1'b1;
      o_sram_a    <= '0;
      o_sram_d    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_grant) begin
          r_win      <= w_winner;
          r_we       <= w_we;
          o_sram_cen <= 1'b0;
          o_sram_wen <= ~w_we;
          o_sram_oen <= w_we;
          o_sram_a   <= (w_winner == REQ_AUX) ? i_aux_addr  : i_cpu_addr;
          o_sram_d   <= (w_winner == REQ_AUX) ? i_aux_wdata : i_cpu_wdata;
          r_state    <= ACCESS;
        end
        ACCESS: begin
          o_sram_cen <= 1'b1;
          o_sram_wen <= 1'b1;
          o_sram_oen <= 1'b1;
          if (!r_we) begin
            if (r_win == REQ_AUX) o_aux_rdata <= i_sram_q;
            else                  o_cpu_rdata <= i_sram_q;
          end
          o_cpu_ack <= (r_win == REQ_CPU);
          o_aux_ack <= (r_win == REQ_AUX);
          r_state   <= DONE;
        end
        DONE: begin
          o_cpu_ack <= 1'b0;
          o_aux_ack <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A waiting requester must hold its command until acked.
  a_cpu_cmd_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ($past(i_cpu_req && !o_cpu_ack) && i_cpu_req) |-> $stable({i_cpu_we, i_cpu_addr, i_cpu_wdata}));
  a_aux_cmd_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ($past(i_aux_req && !o_aux_ack) && i_aux_req) |-> $stable({i_aux_we, i_aux_addr, i_aux_wdata}));
endmodule
